rvh_tlb_miss_arbiter_mc: RTL and testbench
==========================================

Name: rvh_tlb_miss_arbiter_mc

Overview:
- Parametrised N-channel successor to the fixed two-input ITLB/DTLB miss arbiter.
- Sits between N TLB miss ports (ITLB, DTLB, and future vector or prefetch TLBs) and the single shared page-table-walker request/response interface of rvh_mmu.
- Arbitrates among channels using a selectable policy.
- Tracks up to MAX_OUTSTANDING in-flight walks in a tag table and routes each walk response back to its originating channel.
- Quiesces before granting a TLB flush.

Parameters:
- N_CH, 2, number of requesting TLB channels (2..8).
- TRANS_ID_WIDTH, 3, per-channel transaction ID width.
- ASID_WIDTH, 16, ASID width.
- VPN_WIDTH, 27, virtual page number width.
- PTE_WIDTH, 64, PTE width.
- PAGE_LVL_WIDTH, 2, page level width.
- MAX_OUTSTANDING, 4, tag table depth; power of 2, minimum 2.
- TAG_WIDTH, $clog2(MAX_OUTSTANDING), walk tag width (derived).
- ARB_MODE, 0, 0 = round-robin, 1 = fixed priority with anti-starvation.
- PRIO_CH, 1, highest-priority channel in ARB_MODE 1.
- STARVE_LIMIT, 15, consecutive losing cycles before a forced grant (ARB_MODE 1).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- miss_req_vld_i  in  N_CH  per-channel miss request valid.
- miss_req_trans_id_i  in  N_CH*TRANS_ID_WIDTH  per-channel transaction ID.
- miss_req_asid_i  in  N_CH*ASID_WIDTH  per-channel ASID.
- miss_req_vpn_i  in  N_CH*VPN_WIDTH  per-channel VPN.
- miss_req_access_type_i  in  N_CH*2  per-channel access type.
- miss_req_rdy_o  out  N_CH  one-hot accept.
- walk_req_vld_o  out  1  walk request to PTW.
- walk_req_tag_o  out  TAG_WIDTH  tag table index.
- walk_req_asid_o  out  ASID_WIDTH  registered ASID.
- walk_req_vpn_o  out  VPN_WIDTH  registered VPN.
- walk_req_access_type_o  out  2  registered access type.
- walk_req_rdy_i  in  1  PTW accepts.
- walk_resp_vld_i  in  1  walk response valid.
- walk_resp_tag_i  in  TAG_WIDTH  response tag.
- walk_resp_pte_i  in  PTE_WIDTH  leaf PTE.
- walk_resp_page_lvl_i  in  PAGE_LVL_WIDTH  page level.
- walk_resp_access_fault_i  in  1  access fault.
- walk_resp_page_fault_i  in  1  page fault.
- miss_resp_vld_o  out  N_CH  one-hot response valid.
- miss_resp_trans_id_o  out  TRANS_ID_WIDTH  broadcast response payload.
- miss_resp_asid_o  out  ASID_WIDTH  broadcast response payload.
- miss_resp_vpn_o  out  VPN_WIDTH  broadcast response payload.
- miss_resp_access_type_o  out  2  broadcast response payload.
- miss_resp_pte_o  out  PTE_WIDTH  broadcast response payload.
- miss_resp_page_lvl_o  out  PAGE_LVL_WIDTH  broadcast response payload.
- miss_resp_access_fault_o  out  1  broadcast response payload.
- miss_resp_page_fault_o  out  1  broadcast response payload.
- flush_req_i  in  1  level flush request.
- flush_grant_o  out  1  single-cycle flush grant.
- tag_err_o  out  1  sticky: response arrived with an unallocated tag.

Behaviour:
- Reset:
  - All outputs are 0.
  - Tag table is all invalid.
  - Round-robin pointer is 0.
  - Starvation counters are 0.
  - Flush FSM is in IDLE.
  - Reset mid-walk discards all entries; late responses then set tag_err_o.
- can_accept = (FSM == IDLE) & table not full & (!walk_req_vld_o | walk_req_rdy_i).
- miss_req_rdy_o = winner one-hot & can_accept, combinational from miss_req_vld_i. A channel may drop vld without being accepted.
- Round-robin (ARB_MODE 0):
  - Search starts at the pointer.
  - On accept, the pointer moves to winner+1, wrapping N_CH-1 -> 0.
- Fixed priority (ARB_MODE 1):
  - Order is PRIO_CH first, then ascending index with wrap.
  - Each channel has a 4-bit+ saturating counter. It increments while the channel is valid and not accepted, and clears on accept or when vld drops.
  - A counter reaching STARVE_LIMIT forces that channel to win. If several are forced, the lowest index wins.
- Accept, same cycle:
  - Allocate the lowest-index free tag.
  - Store {ch, trans_id, asid, vpn, access_type} in that entry.
  - Load the walk_req_* registers; walk_req_vld_o is 1 the next cycle (1-cycle request latency).
- walk_req_* is held stable while vld & !rdy. It clears on rdy unless a new accept happens in the same cycle (back-to-back throughput of 1 per cycle).
- Response:
  - On walk_resp_vld_i with a valid tag, the entry is freed that cycle.
  - Next cycle, miss_resp_vld_o[entry.ch]=1 for exactly one cycle with the stored fields plus the PTW result. There is no backpressure to TLBs.
  - A response with an invalid tag is dropped and sets tag_err_o, cleared only by rst.
- Free and allocate in the same cycle: an entry freed this cycle is not reusable until the next cycle. "Full" is evaluated on pre-free state.
- Flush FSM:
  - IDLE -> DRAIN on flush_req_i. Accepts are blocked from that cycle.
  - DRAIN -> GRANT when !walk_req_vld_o and the table is empty. Responses are still delivered during DRAIN.
  - GRANT: flush_grant_o=1 for one cycle, then -> IDLE.
  - If flush_req_i is still high in IDLE, a new flush begins.

Test Plan:
- N_CH=2, RR, both channels valid continuously, walk_req_rdy_i=1, in-order responses 2 cycles later:
  - Grants alternate ch0, ch1, ch0, ...
  - Tags go 0, 1, 2, 3, 0, ...
  - Each miss_resp_vld_o returns the correct trans_id.
- MAX_OUTSTANDING=4, no responses:
  - Four accepts occur, then miss_req_rdy_o=0.
  - A response to tag 2 frees the entry.
  - The next accept, one cycle later, uses tag 2.
- walk_req_rdy_i=0 for 5 cycles with ch1 request pending:
  - walk_req_vpn_o and walk_req_tag_o stay stable.
  - No further accept occurs until rdy returns.
- ARB_MODE=1, PRIO_CH=1, STARVE_LIMIT=15, ch1 valid every cycle, ch0 valid:
  - ch0 is granted exactly once, on its 16th waiting cycle.
  - ch1 wins every other cycle.
- Two outstanding walks, flush_req_i pulsed:
  - No new accepts occur.
  - Both responses are delivered.
  - flush_grant_o is high for one cycle after the table empties.
- Response with tag 3 when entry 3 is invalid:
  - No miss_resp_vld_o is asserted.
  - tag_err_o=1 and stays 1 until rst.

Source files
------------

// File: rtl/rvh_tlb_miss_arbiter_mc.sv
// rvh_tlb_miss_arbiter_mc: N-channel TLB miss arbiter with walk tag table and flush quiesce
module rvh_tlb_miss_arbiter_mc #(
    parameter int N_CH            = 2,
    parameter int TRANS_ID_WIDTH  = 3,
    parameter int ASID_WIDTH      = 16,
    parameter int VPN_WIDTH       = 27,
    parameter int PTE_WIDTH       = 64,
    parameter int PAGE_LVL_WIDTH  = 2,
    parameter int MAX_OUTSTANDING = 4,
    parameter int TAG_WIDTH       = $clog2(MAX_OUTSTANDING),
    parameter int ARB_MODE        = 0,
    parameter int PRIO_CH         = 1,
    parameter int STARVE_LIMIT    = 15
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [N_CH-1:0]                  miss_req_vld_i,
    input  logic [N_CH*TRANS_ID_WIDTH-1:0]   miss_req_trans_id_i,
    input  logic [N_CH*ASID_WIDTH-1:0]       miss_req_asid_i,
    input  logic [N_CH*VPN_WIDTH-1:0]        miss_req_vpn_i,
    input  logic [N_CH*2-1:0]                miss_req_access_type_i,
    output logic [N_CH-1:0]                  miss_req_rdy_o,
    output logic                             walk_req_vld_o,
    output logic [TAG_WIDTH-1:0]             walk_req_tag_o,
    output logic [ASID_WIDTH-1:0]            walk_req_asid_o,
    output logic [VPN_WIDTH-1:0]             walk_req_vpn_o,
    output logic [1:0]                       walk_req_access_type_o,
    input  logic                             walk_req_rdy_i,
    input  logic                             walk_resp_vld_i,
    input  logic [TAG_WIDTH-1:0]             walk_resp_tag_i,
    input  logic [PTE_WIDTH-1:0]             walk_resp_pte_i,
    input  logic [PAGE_LVL_WIDTH-1:0]        walk_resp_page_lvl_i,
    input  logic                             walk_resp_access_fault_i,
    input  logic                             walk_resp_page_fault_i,
    output logic [N_CH-1:0]                  miss_resp_vld_o,
    output logic [TRANS_ID_WIDTH-1:0]        miss_resp_trans_id_o,
    output logic [ASID_WIDTH-1:0]            miss_resp_asid_o,
    output logic [VPN_WIDTH-1:0]             miss_resp_vpn_o,
    output logic [1:0]                       miss_resp_access_type_o,
    output logic [PTE_WIDTH-1:0]             miss_resp_pte_o,
    output logic [PAGE_LVL_WIDTH-1:0]        miss_resp_page_lvl_o,
    output logic                             miss_resp_access_fault_o,
    output logic                             miss_resp_page_fault_o,
    input  logic                             flush_req_i,
    output logic                             flush_grant_o,
    output logic                             tag_err_o
);
    localparam int CH_W  = $clog2(N_CH);
    localparam int CNT_W = ($clog2(STARVE_LIMIT + 1) > 4) ? $clog2(STARVE_LIMIT + 1) : 4;

    typedef enum logic [1:0] {IDLE, DRAIN, GRANT} state_t;

    state_t                      state_q;
    logic                        flush_grant_q;
    logic [MAX_OUTSTANDING-1:0]  tv_q, tv_d;
    logic [CH_W-1:0]             tch_q  [MAX_OUTSTANDING];
    logic [TRANS_ID_WIDTH-1:0]   ttid_q [MAX_OUTSTANDING];
    logic [ASID_WIDTH-1:0]       tasid_q[MAX_OUTSTANDING];
    logic [VPN_WIDTH-1:0]        tvpn_q [MAX_OUTSTANDING];
    logic [1:0]                  tat_q  [MAX_OUTSTANDING];
    logic [CH_W-1:0]             rr_ptr_q, rr_ptr_d, start, win_idx, forced_idx;
    logic [CNT_W-1:0]            cnt_q[N_CH], cnt_d[N_CH];
    logic [N_CH-1:0]             win_oh;
    logic                        found, forced;
    logic [TAG_WIDTH-1:0]        free_tag;
    logic                        full, can_accept, accept, resp_hit;
    logic                        wr_vld_q, wr_vld_d;
    logic [TAG_WIDTH-1:0]        wr_tag_q, wr_tag_d;
    logic [ASID_WIDTH-1:0]       wr_asid_q, wr_asid_d;
    logic [VPN_WIDTH-1:0]        wr_vpn_q, wr_vpn_d;
    logic [1:0]                  wr_at_q, wr_at_d;
    logic [N_CH-1:0]             mr_vld_q, mr_vld_d;
    logic [TRANS_ID_WIDTH-1:0]   mr_tid_q, mr_tid_d;
    logic [ASID_WIDTH-1:0]       mr_asid_q, mr_asid_d;
    logic [VPN_WIDTH-1:0]        mr_vpn_q, mr_vpn_d;
    logic [1:0]                  mr_at_q, mr_at_d;
    logic [PTE_WIDTH-1:0]        mr_pte_q, mr_pte_d;
    logic [PAGE_LVL_WIDTH-1:0]   mr_lvl_q, mr_lvl_d;
    logic                        mr_af_q, mr_af_d, mr_pf_q, mr_pf_d;
    logic                        tag_err_q, tag_err_d;

    // Winner selection: rotating search from the RR pointer or PRIO_CH, overridden by the lowest starved channel
    always_comb begin
        start      = (ARB_MODE == 1) ? CH_W'(PRIO_CH) : rr_ptr_q;
        found      = 1'b0;
        win_idx    = '0;
        forced     = 1'b0;
        forced_idx = '0;
        for (int i = 0; i < N_CH; i++) begin
            if (!found && miss_req_vld_i[CH_W'((int'(start) + i) % N_CH)]) begin
                found   = 1'b1;
                win_idx = CH_W'((int'(start) + i) % N_CH);
            end
        end
        for (int i = N_CH - 1; i >= 0; i--) begin
            if (ARB_MODE == 1 && miss_req_vld_i[i] && cnt_q[i] >= CNT_W'(STARVE_LIMIT)) begin
                forced     = 1'b1;
                forced_idx = CH_W'(i);
            end
        end
        win_idx = forced ? forced_idx : win_idx;
        win_oh  = found ? (N_CH'(1) << win_idx) : '0;
    end

    // Lowest free tag; an entry freed this cycle still counts as busy
    always_comb begin
        free_tag = '0;
        for (int t = MAX_OUTSTANDING - 1; t >= 0; t--) begin
            if (!tv_q[t]) free_tag = TAG_WIDTH'(t);
        end
    end

    assign full           = &tv_q;
    assign can_accept     = !rst && state_q == IDLE && !full && (!wr_vld_q || walk_req_rdy_i);
    assign miss_req_rdy_o = can_accept ? win_oh : '0;
    assign accept         = |miss_req_rdy_o;
    assign resp_hit       = walk_resp_vld_i && tv_q[walk_resp_tag_i];

    // Next state for table valids, arbitration state, walk request and response registers
    always_comb begin
        tv_d = tv_q;
        if (resp_hit) tv_d[walk_resp_tag_i] = 1'b0;
        if (accept) tv_d[free_tag] = 1'b1;
        rr_ptr_d = !accept ? rr_ptr_q : (win_idx == CH_W'(N_CH - 1)) ? '0 : win_idx + 1'b1;
        for (int i = 0; i < N_CH; i++) begin
            cnt_d[i] = (!miss_req_vld_i[i] || miss_req_rdy_o[i]) ? '0 : (&cnt_q[i]) ? cnt_q[i] : cnt_q[i] + 1'b1;
        end
        wr_vld_d  = accept || (wr_vld_q && !walk_req_rdy_i);
        wr_tag_d  = accept ? free_tag : wr_tag_q;
        wr_asid_d = accept ? miss_req_asid_i[win_idx*ASID_WIDTH +: ASID_WIDTH] : wr_asid_q;
        wr_vpn_d  = accept ? miss_req_vpn_i[win_idx*VPN_WIDTH +: VPN_WIDTH] : wr_vpn_q;
        wr_at_d   = accept ? miss_req_access_type_i[win_idx*2 +: 2] : wr_at_q;
        mr_vld_d  = resp_hit ? (N_CH'(1) << tch_q[walk_resp_tag_i]) : '0;
        mr_tid_d  = resp_hit ? ttid_q[walk_resp_tag_i] : mr_tid_q;
        mr_asid_d = resp_hit ? tasid_q[walk_resp_tag_i] : mr_asid_q;
        mr_vpn_d  = resp_hit ? tvpn_q[walk_resp_tag_i] : mr_vpn_q;
        mr_at_d   = resp_hit ? tat_q[walk_resp_tag_i] : mr_at_q;
        mr_pte_d  = resp_hit ? walk_resp_pte_i : mr_pte_q;
        mr_lvl_d  = resp_hit ? walk_resp_page_lvl_i : mr_lvl_q;
        mr_af_d   = resp_hit ? walk_resp_access_fault_i : mr_af_q;
        mr_pf_d   = resp_hit ? walk_resp_page_fault_i : mr_pf_q;
        tag_err_d = tag_err_q || (walk_resp_vld_i && !tv_q[walk_resp_tag_i]);
    end

    // Control and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            tv_q      <= '0;
            rr_ptr_q  <= '0;
            for (int i = 0; i < N_CH; i++) cnt_q[i] <= '0;
            wr_vld_q  <= 1'b0;
            wr_tag_q  <= '0;
            wr_asid_q <= '0;
            wr_vpn_q  <= '0;
            wr_at_q   <= '0;
            mr_vld_q  <= '0;
            mr_tid_q  <= '0;
            mr_asid_q <= '0;
            mr_vpn_q  <= '0;
            mr_at_q   <= '0;
            mr_pte_q  <= '0;
            mr_lvl_q  <= '0;
            mr_af_q   <= 1'b0;
            mr_pf_q   <= 1'b0;
            tag_err_q <= 1'b0;
        end else begin
            tv_q      <= tv_d;
            rr_ptr_q  <= rr_ptr_d;
            for (int i = 0; i < N_CH; i++) cnt_q[i] <= cnt_d[i];
            wr_vld_q  <= wr_vld_d;
            wr_tag_q  <= wr_tag_d;
            wr_asid_q <= wr_asid_d;
            wr_vpn_q  <= wr_vpn_d;
            wr_at_q   <= wr_at_d;
            mr_vld_q  <= mr_vld_d;
            mr_tid_q  <= mr_tid_d;
            mr_asid_q <= mr_asid_d;
            mr_vpn_q  <= mr_vpn_d;
            mr_at_q   <= mr_at_d;
            mr_pte_q  <= mr_pte_d;
            mr_lvl_q  <= mr_lvl_d;
            mr_af_q   <= mr_af_d;
            mr_pf_q   <= mr_pf_d;
            tag_err_q <= tag_err_d;
        end
    end

    // Tag table payload, written into the allocated entry on accept
    always_ff @(posedge clk) begin
        if (accept) begin
            tch_q[free_tag]   <= win_idx;
            ttid_q[free_tag]  <= miss_req_trans_id_i[win_idx*TRANS_ID_WIDTH +: TRANS_ID_WIDTH];
            tasid_q[free_tag] <= wr_asid_d;
            tvpn_q[free_tag]  <= wr_vpn_d;
            tat_q[free_tag]   <= wr_at_d;
        end
    end

    // Flush FSM: block accepts, wait for the walk port and table to drain, then pulse the grant
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            flush_grant_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: if (flush_req_i) state_q <= DRAIN;
                DRAIN: if (!wr_vld_q && !(|tv_q)) begin
                    state_q       <= GRANT;
                    flush_grant_q <= 1'b1;
                end
                GRANT: begin
                    state_q       <= IDLE;
                    flush_grant_q <= 1'b0;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign walk_req_vld_o           = wr_vld_q;
    assign walk_req_tag_o           = wr_tag_q;
    assign walk_req_asid_o          = wr_asid_q;
    assign walk_req_vpn_o           = wr_vpn_q;
    assign walk_req_access_type_o   = wr_at_q;
    assign miss_resp_vld_o          = mr_vld_q;
    assign miss_resp_trans_id_o     = mr_tid_q;
    assign miss_resp_asid_o         = mr_asid_q;
    assign miss_resp_vpn_o          = mr_vpn_q;
    assign miss_resp_access_type_o  = mr_at_q;
    assign miss_resp_pte_o          = mr_pte_q;
    assign miss_resp_page_lvl_o     = mr_lvl_q;
    assign miss_resp_access_fault_o = mr_af_q;
    assign miss_resp_page_fault_o   = mr_pf_q;
    assign flush_grant_o            = flush_grant_q;
    assign tag_err_o                = tag_err_q;
endmodule

// File: tb/tb_rvh_tlb_miss_arbiter_mc.sv
// tb_rvh_tlb_miss_arbiter_mc: directed checks of round-robin and fixed-priority arbiter instances
module tb_rvh_tlb_miss_arbiter_mc;
    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  vld;
    logic [5:0]  tid;
    logic [31:0] asid;
    logic [53:0] vpn;
    logic [3:0]  at;
    logic        wrdy, rvld, af, pf, flush;
    logic [1:0]  rtag, lvl;
    logic [63:0] pte;

    logic [1:0]  rdy_r, wtag_r, wat_r, mvld_r, mat_r, mlvl_r;
    logic        wvld_r, maf_r, mpf_r, fg_r, terr_r;
    logic [15:0] wasid_r, masid_r;
    logic [26:0] wvpn_r, mvpn_r;
    logic [2:0]  mtid_r;
    logic [63:0] mpte_r;

    logic [1:0]  rdy_f, wtag_f, wat_f, mvld_f, mat_f, mlvl_f;
    logic        wvld_f, maf_f, mpf_f, fg_f, terr_f;
    logic [15:0] wasid_f, masid_f;
    logic [26:0] wvpn_f, mvpn_f;
    logic [2:0]  mtid_f;
    logic [63:0] mpte_f;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    rvh_tlb_miss_arbiter_mc #(.ARB_MODE(0)) dut_rr (
        .clk(clk), .rst(rst),
        .miss_req_vld_i(vld), .miss_req_trans_id_i(tid), .miss_req_asid_i(asid),
        .miss_req_vpn_i(vpn), .miss_req_access_type_i(at), .miss_req_rdy_o(rdy_r),
        .walk_req_vld_o(wvld_r), .walk_req_tag_o(wtag_r), .walk_req_asid_o(wasid_r),
        .walk_req_vpn_o(wvpn_r), .walk_req_access_type_o(wat_r), .walk_req_rdy_i(wrdy),
        .walk_resp_vld_i(rvld), .walk_resp_tag_i(rtag), .walk_resp_pte_i(pte),
        .walk_resp_page_lvl_i(lvl), .walk_resp_access_fault_i(af), .walk_resp_page_fault_i(pf),
        .miss_resp_vld_o(mvld_r), .miss_resp_trans_id_o(mtid_r), .miss_resp_asid_o(masid_r),
        .miss_resp_vpn_o(mvpn_r), .miss_resp_access_type_o(mat_r), .miss_resp_pte_o(mpte_r),
        .miss_resp_page_lvl_o(mlvl_r), .miss_resp_access_fault_o(maf_r),
        .miss_resp_page_fault_o(mpf_r), .flush_req_i(flush), .flush_grant_o(fg_r), .tag_err_o(terr_r)
    );

    rvh_tlb_miss_arbiter_mc #(.ARB_MODE(1), .PRIO_CH(1), .STARVE_LIMIT(15)) dut_fp (
        .clk(clk), .rst(rst),
        .miss_req_vld_i(vld), .miss_req_trans_id_i(tid), .miss_req_asid_i(asid),
        .miss_req_vpn_i(vpn), .miss_req_access_type_i(at), .miss_req_rdy_o(rdy_f),
        .walk_req_vld_o(wvld_f), .walk_req_tag_o(wtag_f), .walk_req_asid_o(wasid_f),
        .walk_req_vpn_o(wvpn_f), .walk_req_access_type_o(wat_f), .walk_req_rdy_i(wrdy),
        .walk_resp_vld_i(rvld), .walk_resp_tag_i(rtag), .walk_resp_pte_i(pte),
        .walk_resp_page_lvl_i(lvl), .walk_resp_access_fault_i(af), .walk_resp_page_fault_i(pf),
        .miss_resp_vld_o(mvld_f), .miss_resp_trans_id_o(mtid_f), .miss_resp_asid_o(masid_f),
        .miss_resp_vpn_o(mvpn_f), .miss_resp_access_type_o(mat_f), .miss_resp_pte_o(mpte_f),
        .miss_resp_page_lvl_o(mlvl_f), .miss_resp_access_fault_o(maf_f),
        .miss_resp_page_fault_o(mpf_f), .flush_req_i(flush), .flush_grant_o(fg_f), .tag_err_o(terr_f)
    );

    task automatic idle_inputs();
        vld = '0; tid = '0; asid = '0; vpn = '0; at = '0;
        wrdy = 1'b1; rvld = 1'b0; rtag = '0; pte = '0; lvl = '0; af = 1'b0; pf = 1'b0; flush = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1'b1;
        @(posedge clk); @(posedge clk); #1;
        vectors++;
        if ({rdy_r, wvld_r, wtag_r, mvld_r, fg_r, terr_r} !== 9'b0) begin
            miscompares++;
            $display("FAIL reset_rr ctrl got=%b want=0", {rdy_r, wvld_r, wtag_r, mvld_r, fg_r, terr_r});
        end
        vectors++;
        if ({wasid_r, wvpn_r, mtid_r, mpte_r} !== 110'b0) begin
            miscompares++;
            $display("FAIL reset_rr payload got=%h want=0", {wasid_r, wvpn_r, mtid_r, mpte_r});
        end
        vectors++;
        if ({rdy_f, wvld_f, wtag_f, mvld_f, fg_f, terr_f} !== 9'b0) begin
            miscompares++;
            $display("FAIL reset_fp ctrl got=%b want=0", {rdy_f, wvld_f, wtag_f, mvld_f, fg_f, terr_f});
        end
        rst = 1'b0;
    endtask

    task automatic test_round_robin();
        do_reset();
        for (int c = 0; c < 10; c++) begin
            vld = 2'b11;
            tid = {3'(~c), 3'(c)};
            vpn = {27'(c + 100), 27'(c)};
            rvld = (c >= 3);
            rtag = 2'(c - 3);
            pte = 64'(c);
            #1;
            vectors++;
            if (rdy_r !== ((c % 2 == 1) ? 2'b10 : 2'b01)) begin
                miscompares++;
                $display("FAIL rr_grant c=%0d got=%b", c, rdy_r);
            end
            if (c >= 1) begin
                vectors++;
                if ({wvld_r, wtag_r, wvpn_r} !== {1'b1, 2'(c - 1), ((c - 1) % 2 == 1) ? 27'(c + 99) : 27'(c - 1)}) begin
                    miscompares++;
                    $display("FAIL rr_walk_req c=%0d got vld=%b tag=%0d vpn=%0d", c, wvld_r, wtag_r, wvpn_r);
                end
            end
            if (c >= 4) begin
                vectors++;
                if ({mvld_r, mtid_r, mpte_r} !== {((c - 4) % 2 == 1) ? 2'b10 : 2'b01,
                                                  ((c - 4) % 2 == 1) ? 3'(~(c - 4)) : 3'(c - 4), 64'(c - 1)}) begin
                    miscompares++;
                    $display("FAIL rr_miss_resp c=%0d got vld=%b tid=%0d pte=%0d", c, mvld_r, mtid_r, mpte_r);
                end
            end
            step();
        end
        idle_inputs();
        #1;
        vectors++;
        if (terr_r !== 1'b0) begin
            miscompares++;
            $display("FAIL rr_no_tag_err got=%b want=0", terr_r);
        end
    endtask

    task automatic test_capacity();
        do_reset();
        for (int c = 0; c < 9; c++) begin
            vld = (c <= 7) ? 2'b01 : 2'b00;
            vpn = {27'd0, 27'(c + 200)};
            rvld = (c == 6);
            rtag = 2'd2;
            #1;
            if (c <= 7) begin
                vectors++;
                if (rdy_r !== ((c < 4 || c == 7) ? 2'b01 : 2'b00)) begin
                    miscompares++;
                    $display("FAIL cap_rdy c=%0d got=%b", c, rdy_r);
                end
            end
            if (c >= 1 && c <= 4) begin
                vectors++;
                if ({wvld_r, wtag_r} !== {1'b1, 2'(c - 1)}) begin
                    miscompares++;
                    $display("FAIL cap_tag c=%0d got vld=%b tag=%0d", c, wvld_r, wtag_r);
                end
            end
            if (c == 7) begin
                vectors++;
                if (mvld_r !== 2'b01) begin
                    miscompares++;
                    $display("FAIL cap_free_resp got=%b want=01", mvld_r);
                end
            end
            if (c == 8) begin
                vectors++;
                if ({wvld_r, wtag_r, wvpn_r} !== {1'b1, 2'd2, 27'd207}) begin
                    miscompares++;
                    $display("FAIL cap_reuse got vld=%b tag=%0d vpn=%0d want 1/2/207", wvld_r, wtag_r, wvpn_r);
                end
            end
            step();
        end
        idle_inputs();
    endtask

    task automatic test_stall();
        do_reset();
        for (int c = 0; c < 8; c++) begin
            vld = (c <= 6) ? 2'b10 : 2'b00;
            vpn = {(c == 0) ? 27'h1234567 : 27'h7654321, 27'd0};
            wrdy = (c == 0 || c >= 6);
            #1;
            if (c <= 6) begin
                vectors++;
                if (rdy_r !== ((c == 0 || c == 6) ? 2'b10 : 2'b00)) begin
                    miscompares++;
                    $display("FAIL stall_rdy c=%0d got=%b", c, rdy_r);
                end
            end
            if (c >= 1 && c <= 6) begin
                vectors++;
                if ({wvld_r, wtag_r, wvpn_r} !== {1'b1, 2'd0, 27'h1234567}) begin
                    miscompares++;
                    $display("FAIL stall_hold c=%0d got vld=%b tag=%0d vpn=%h", c, wvld_r, wtag_r, wvpn_r);
                end
            end
            if (c == 7) begin
                vectors++;
                if ({wvld_r, wtag_r, wvpn_r} !== {1'b1, 2'd1, 27'h7654321}) begin
                    miscompares++;
                    $display("FAIL stall_next got vld=%b tag=%0d vpn=%h", wvld_r, wtag_r, wvpn_r);
                end
            end
            step();
        end
        idle_inputs();
    endtask

    task automatic test_flush();
        do_reset();
        for (int c = 0; c < 9; c++) begin
            vld = (c <= 1 || c >= 3) ? 2'b11 : 2'b00;
            tid = {3'd6, 3'd3};
            flush = (c == 2);
            rvld = (c == 4 || c == 5);
            rtag = (c == 4) ? 2'd0 : 2'd1;
            #1;
            vectors++;
            if (rdy_r !== ((c == 0 || c == 8) ? 2'b01 : (c == 1) ? 2'b10 : 2'b00)) begin
                miscompares++;
                $display("FAIL flush_rdy c=%0d got=%b", c, rdy_r);
            end
            if (c >= 3) begin
                vectors++;
                if (fg_r !== (c == 7)) begin
                    miscompares++;
                    $display("FAIL flush_grant c=%0d got=%b", c, fg_r);
                end
            end
            if (c == 5 || c == 6) begin
                vectors++;
                if ({mvld_r, mtid_r} !== ((c == 5) ? {2'b01, 3'd3} : {2'b10, 3'd6})) begin
                    miscompares++;
                    $display("FAIL flush_drain_resp c=%0d got vld=%b tid=%0d", c, mvld_r, mtid_r);
                end
            end
            step();
        end
        idle_inputs();
    endtask

    task automatic test_tag_err();
        do_reset();
        rvld = 1'b1;
        rtag = 2'd3;
        step();
        rvld = 1'b0;
        for (int c = 0; c < 4; c++) begin
            #1;
            vectors++;
            if ({mvld_r, terr_r} !== 3'b001) begin
                miscompares++;
                $display("FAIL tag_err c=%0d got resp=%b err=%b want 00/1", c, mvld_r, terr_r);
            end
            step();
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        vectors++;
        if (terr_r !== 1'b0) begin
            miscompares++;
            $display("FAIL tag_err_clear got=%b want=0", terr_r);
        end
    endtask

    task automatic test_starvation();
        do_reset();
        for (int c = 0; c < 20; c++) begin
            vld = 2'b11;
            rvld = (c >= 3);
            rtag = 2'(c - 3);
            #1;
            vectors++;
            if (rdy_f !== ((c == 15) ? 2'b01 : 2'b10)) begin
                miscompares++;
                $display("FAIL starve_grant c=%0d got=%b", c, rdy_f);
            end
            if (c >= 4) begin
                vectors++;
                if (mvld_f !== ((c == 19) ? 2'b01 : 2'b10)) begin
                    miscompares++;
                    $display("FAIL starve_resp c=%0d got=%b", c, mvld_f);
                end
            end
            step();
        end
        idle_inputs();
        #1;
        vectors++;
        if (terr_f !== 1'b0) begin
            miscompares++;
            $display("FAIL starve_no_tag_err got=%b want=0", terr_f);
        end
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_capacity();
        test_stall();
        test_flush();
        test_tag_err();
        test_starvation();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
